// File: rtl/isp_raw_tx.sv
// isp_raw_tx: turns a valid/ready pixel stream into pclk/href/vsync raw video frame timing.
// Latency: 1 cycle from an active slot to out_href/out_raw; all status outputs are registered the same way.
// Backpressure: in_ready is high only in active slots; timing never stalls, and a missing pixel gives a 0 output and sets sticky underflow.
module isp_raw_tx #(
  parameter int BITS    = 8,
  parameter int WIDTH   = 1280,
  parameter int HEIGHT  = 960,
  parameter int H_BLANK = 160,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 2,
  parameter int V_FRONT = 2
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_start,
  output logic            frame_done,
  output logic            busy,
  output logic            underflow
);

  localparam int LINE_LEN = WIDTH + H_BLANK;
  localparam int MAX_A    = (LINE_LEN > HEIGHT) ? LINE_LEN : HEIGHT;
  localparam int MAX_B    = (MAX_A > V_SYNC) ? MAX_A : V_SYNC;
  localparam int MAX_C    = (MAX_B > V_BACK) ? MAX_B : V_BACK;
  localparam int MAX_D    = (MAX_C > V_FRONT) ? MAX_C : V_FRONT;
  localparam int CW       = $clog2(MAX_D + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   h_cnt;
  logic [CW-1:0]   v_cnt;
  logic            line_end;

  logic            href_d;
  logic            vsync_d;
  logic [BITS-1:0] raw_d;
  logic            fs_d;
  logic            fd_d;
  logic            busy_d;
  logic            under_d;

  assign line_end = (h_cnt == CW'(LINE_LEN - 1));

  // State register plus the horizontal/vertical position counters; v_cnt restarts on every state change.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else begin
        h_cnt <= line_end ? '0 : h_cnt + CW'(1);
        if (line_end) begin
          v_cnt <= (state_nxt != state) ? '0 : v_cnt + CW'(1);
        end
      end
    end
  end

  // Frame sequencing; enable only matters in IDLE and at the very end of a frame, so frames are never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (line_end && v_cnt == CW'(V_SYNC - 1))
          state_nxt = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
      end
      ST_VBACK: begin
        if (line_end && v_cnt == CW'(V_BACK - 1))
          state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (line_end && v_cnt == CW'(HEIGHT - 1)) begin
          if (V_FRONT > 0)  state_nxt = ST_VFRONT;
          else if (enable)  state_nxt = ST_VSYNC;
          else              state_nxt = ST_IDLE;
        end
      end
      ST_VFRONT: begin
        if (line_end && v_cnt == CW'(V_FRONT - 1))
          state_nxt = enable ? ST_VSYNC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle output decode from the current position; everything except in_ready is registered below.
  always_comb begin
    in_ready = (state == ST_ACTIVE) && (h_cnt < CW'(WIDTH));
    href_d   = in_ready;
    raw_d    = (in_ready && in_valid) ? in_data : '0;
    under_d  = underflow | (in_ready & ~in_valid);
    vsync_d  = (state == ST_VSYNC);
    fs_d     = (state == ST_VSYNC) && (h_cnt == '0) && (v_cnt == '0);
    busy_d   = (state != ST_IDLE);
    if (V_FRONT > 0)
      fd_d = line_end && (state == ST_VFRONT) && (v_cnt == CW'(V_FRONT - 1));
    else
      fd_d = line_end && (state == ST_ACTIVE) && (v_cnt == CW'(HEIGHT - 1));
  end

  // Output register stage: one cycle behind the position counters, all fields aligned.
  always_ff @(posedge pclk) begin
    if (rst) begin
      out_href    <= 1'b0;
      out_vsync   <= 1'b0;
      out_raw     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      out_href    <= href_d;
      out_vsync   <= vsync_d;
      out_raw     <= raw_d;
      frame_start <= fs_d;
      frame_done  <= fd_d;
      busy        <= busy_d;
      underflow   <= under_d;
    end
  end

endmodule
